// File: rtl/junction_controller.sv
// Two-road junction sequencer: NS rests green, EW and pedestrian requests are latched and served.
// Lamps, walk, ped_ack and phase are registered decodes of the next state and change on the state edge.
module junction_controller #(
  parameter int GREEN_CYCLES     = 8,
  parameter int AMBER_CYCLES     = 3,
  parameter int RED_AMBER_CYCLES = 2,
  parameter int CLEAR_CYCLES     = 2,
  parameter int WALK_CYCLES      = 6,
  parameter int CNT_W            = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ew_req,
  input  logic       ped_req,
  output logic [2:0] ns_rag,
  output logic [2:0] ew_rag,
  output logic       walk,
  output logic       ped_ack,
  output logic [3:0] phase
);

  typedef enum logic [3:0] {
    CLR_NS   = 4'd0,
    NS_RA    = 4'd1,
    NS_GREEN = 4'd2,
    NS_AMBER = 4'd3,
    CLR_EW   = 4'd4,
    EW_RA    = 4'd5,
    EW_GREEN = 4'd6,
    EW_AMBER = 4'd7,
    WALK     = 4'd8
  } state_t;

  localparam logic [2:0] RED   = 3'b100;
  localparam logic [2:0] RA    = 3'b110;
  localparam logic [2:0] GREEN = 3'b001;
  localparam logic [2:0] AMBER = 3'b010;

  localparam logic [CNT_W-1:0] GREEN_LD = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] AMBER_LD = CNT_W'(AMBER_CYCLES - 1);
  localparam logic [CNT_W-1:0] RA_LD    = CNT_W'(RED_AMBER_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLEAR_LD = CNT_W'(CLEAR_CYCLES - 1);
  localparam logic [CNT_W-1:0] WALK_LD  = CNT_W'(WALK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  state_t           nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_load;
  logic             ew_pending;
  logic             ped_pending;
  logic             next_dir;   // 0: WALK resumes NS, 1: WALK resumes EW
  logic             cnt_done;
  logic             entering;

  assign cnt_done = (cnt == '0);
  assign entering = (nxt != state);

  always_comb begin
    nxt = state;
    case (state)
      CLR_NS:   if (cnt_done) nxt = ped_pending ? WALK : NS_RA;
      NS_RA:    if (cnt_done) nxt = NS_GREEN;
      NS_GREEN: if (cnt_done && (ew_pending || ped_pending)) nxt = NS_AMBER;
      NS_AMBER: if (cnt_done) nxt = CLR_EW;
      CLR_EW:   if (cnt_done) nxt = ped_pending ? WALK : EW_RA;
      EW_RA:    if (cnt_done) nxt = EW_GREEN;
      EW_GREEN: if (cnt_done) nxt = EW_AMBER;
      EW_AMBER: if (cnt_done) nxt = CLR_NS;
      WALK:     if (cnt_done) nxt = next_dir ? EW_RA : NS_RA;
      default:  nxt = CLR_NS;
    endcase
  end

  always_comb begin
    cnt_load = CLEAR_LD;
    case (nxt)
      NS_RA, EW_RA:       cnt_load = RA_LD;
      NS_GREEN, EW_GREEN: cnt_load = GREEN_LD;
      NS_AMBER, EW_AMBER: cnt_load = AMBER_LD;
      WALK:               cnt_load = WALK_LD;
      default:            cnt_load = CLEAR_LD;
    endcase
  end

  function automatic logic [6:0] decode(input state_t s);
    logic [6:0] d;
    d = {RED, RED, 1'b0};
    case (s)
      NS_RA:    d = {RA,    RED,   1'b0};
      NS_GREEN: d = {GREEN, RED,   1'b0};
      NS_AMBER: d = {AMBER, RED,   1'b0};
      EW_RA:    d = {RED,   RA,    1'b0};
      EW_GREEN: d = {RED,   GREEN, 1'b0};
      EW_AMBER: d = {RED,   AMBER, 1'b0};
      WALK:     d = {RED,   RED,   1'b1};
      default:  d = {RED,   RED,   1'b0};
    endcase
    return d;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= CLR_NS;
      cnt         <= CLEAR_LD;
      next_dir    <= 1'b0;
      ew_pending  <= 1'b0;
      ped_pending <= 1'b0;
      ns_rag      <= RED;
      ew_rag      <= RED;
      walk        <= 1'b0;
      ped_ack     <= 1'b0;
      phase       <= 4'd0;
    end else begin
      state <= nxt;
      if (entering)
        cnt <= cnt_load;
      else if (!cnt_done)
        cnt <= cnt - CNT_ONE;
      if (entering && nxt == WALK)
        next_dir <= (state == CLR_EW);
      // Clearing on the service entry edge absorbs a request sampled on that same edge.
      ew_pending  <= (entering && nxt == EW_GREEN) ? 1'b0 : (ew_pending | ew_req);
      ped_pending <= (entering && nxt == WALK) ? 1'b0 : (ped_pending | ped_req);
      {ns_rag, ew_rag, walk} <= decode(nxt);
      ped_ack <= entering && (nxt == WALK);
      phase   <= nxt;
    end
  end

endmodule

// File: doc/junction_controller.md
# junction_controller

Sequences the lamps of a two-road junction. The major road is north-south (NS) and the minor road is east-west (EW). Each road's lamp set uses the same red/amber/green cycle as the single-set lights block. NS rests in green, and the controller serves latched EW vehicle requests and pedestrian requests. Per-phase dwell counters and all-red clearance intervals guarantee that conflicting greens are never shown. It sits between the junction sensors/push-buttons and the two lamp drivers.

## Interface
- GREEN_CYCLES, 8: minimum NS green and fixed EW green duration, in cycles (≥1).
- AMBER_CYCLES, 3: amber duration (≥1).
- RED_AMBER_CYCLES, 2: red+amber duration (≥1).
- CLEAR_CYCLES, 2: all-red clearance duration (≥1).
- WALK_CYCLES, 6: pedestrian walk duration (≥1).
- CNT_W, 8: dwell counter width; every duration parameter is ≤ 2^CNT_W.
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- ew_req  in  1  EW vehicle detected; sampled each cycle and latched.
- ped_req  in  1  pedestrian button; sampled each cycle and latched.
- ns_rag  out  3  NS lamps {red, amber, green}.
- ew_rag  out  3  EW lamps {red, amber, green}.
- walk  out  1  pedestrian walk lamp.
- ped_ack  out  1  one-cycle pulse when a pedestrian request is served.
- phase  out  4  current state encoding, for debug.

## Operation
- Lamp encodings: red=100, red+amber=110, green=001, amber=010. No other value is ever driven.
- The road not named in a state shows 100.
- States, with lamps and exit rule:
  - CLR_NS: both 100 for CLEAR_CYCLES, then WALK if ped_pending, else NS_RA.
  - NS_RA: ns 110 for RED_AMBER_CYCLES, then NS_GREEN.
  - NS_GREEN: ns 001. Dwell ≥ GREEN_CYCLES, then holds indefinitely until ew_pending or ped_pending, then NS_AMBER.
  - NS_AMBER: ns 010 for AMBER_CYCLES, then CLR_EW.
  - CLR_EW: both 100 for CLEAR_CYCLES, then WALK if ped_pending, else EW_RA.
  - EW_RA: ew 110 for RED_AMBER_CYCLES, then EW_GREEN.
  - EW_GREEN: ew 001 for exactly GREEN_CYCLES, then EW_AMBER. It is never truncated or extended.
  - EW_AMBER: ew 010 for AMBER_CYCLES, then CLR_NS.
  - WALK: both 100, walk=1 for WALK_CYCLES. Exits to NS_RA if entered from CLR_NS, or EW_RA if entered from CLR_EW. The next_dir register records which.
- Pending flags:
  - ew_pending is set by ew_req and cleared on entry to EW_GREEN.
  - ped_pending is set by ped_req and cleared on entry to WALK.
  - On the entry edge, clear wins: a request high in the cycle before entry is absorbed by that service.
- After WALK from CLR_EW, the EW phase still runs even if ew_pending=0.
- If ped_pending is set during EW phases, it is served at CLR_NS.
- Both requests pending at NS_GREEN exit: the walk is served at CLR_EW, then EW runs.
- Illegal or unused phase encodings go to CLR_NS on the next edge.
- phase encodings, in order: CLR_NS=0, NS_RA=1, NS_GREEN=2, NS_AMBER=3, CLR_EW=4, EW_RA=5, EW_GREEN=6, EW_AMBER=7, WALK=8.

## Timing
- Reset (async assert, takes effect immediately):
  - state=CLR_NS, dwell counter loaded for CLEAR_CYCLES, next_dir=NS.
  - Pending flags cleared.
  - Outputs: ns_rag=100, ew_rag=100, walk=0, ped_ack=0, phase=0.
- Reset mid-phase aborts the phase immediately to the reset state. Lamps fall to all-red the same instant.
- Dwell counter:
  - Loaded with duration−1 on state entry; the state exits on the edge where it reads 0.
  - Each timed state is therefore visible for exactly N cycles.
  - In NS_GREEN, the counter saturates at 0.
- Outputs are a registered-state decode: lamps change on the same edge as the state, with no extra latency.
- ped_ack is high during the first WALK cycle only.
- Requests take effect one cycle after being sampled. A request sampled on edge k can move NS_GREEN (min elapsed) to NS_AMBER at edge k+1.
- Never allowed: green or amber on both roads at once. Any green/amber transition must pass through ≥CLEAR_CYCLES of all-red.

## Test plan
Parameters for all scenarios: GREEN=4, AMBER=2, RA=2, CLEAR=1, WALK=3.
- Reset release, no requests -> 1 cycle both 100, ns 110×2, then ns 001 held ≥50 cycles, with ew 100 throughout.
- ew_req pulsed one cycle during NS_GREEN after min dwell -> the following sequence, then return to ns 001:
  - ns 010×2, both 100×1, ew 110×2;
  - ew 001×4, ew 010×2, both 100×1;
  - ns 110×2.
- ew_req held high continuously -> the full cycle repeats, with NS green exactly 4 cycles each time.
- ped_req during NS_GREEN -> ns 010×2, CLR_EW×1, then walk=1×3 with ped_ack on its first cycle only, then ew 110. The EW phase runs, and no second walk occurs.
- ped_req during EW_GREEN -> EW completes 4 cycles, then CLR_NS, then WALK×3, then ns 110.
- ped_req and ew_req together -> one walk, one EW phase, and both pending flags end at 0. Also: asserting rst mid-EW_GREEN gives ew_rag=100 immediately, and the sequence restarts as in the reset-release scenario.
- Every scenario asserts each cycle that NS and EW are never both non-100 simultaneously.
